// File: rtl/mem_arbiter_pkg.sv
// Shared bus widths, byte-lane constant and arbiter state encodings.
// Imported by every file that talks to the unified memory port.
package mem_arbiter_pkg;

    localparam int RegBus      = 32;
    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [3:0] SEL_ALL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_IF_BUSY   = 2'd1,
        ST_DATA_BUSY = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates core fetch and load/store onto one single-port memory, alternating under contention.
// Latency: grant registered one cycle after request, done pulses the cycle after mem_ready_i.
// Backpressure: stall_o holds the core until its done pulse; memory paces via mem_ready_i.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = InstAddrBus,
    parameter int DATA_W = RegBus
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_done_o,

    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [3:0]        data_sel_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_done_o,

    output logic              stall_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_sel_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i
);

    arb_state_t state, state_nxt;
    logic       fair;
    logic       grant_if;
    logic       grant_data;
    logic       xfer_done;

    // Data wins in IDLE unless the last completed transfer was data and a fetch is waiting.
    always_comb begin
        state_nxt  = state;
        grant_if   = 1'b0;
        grant_data = 1'b0;
        xfer_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (data_req_i && !(fair && if_req_i)) begin
                    grant_data = 1'b1;
                    state_nxt  = ST_DATA_BUSY;
                end else if (if_req_i) begin
                    grant_if  = 1'b1;
                    state_nxt = ST_IF_BUSY;
                end
            end
            ST_IF_BUSY, ST_DATA_BUSY: begin
                if (mem_ready_i) begin
                    xfer_done = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fair <= 1'b0;
        end else if (xfer_done) begin
            fair <= (state == ST_DATA_BUSY);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_sel_o    <= '0;
            mem_wdata_o  <= '0;
            if_rdata_o   <= '0;
            data_rdata_o <= '0;
            if_done_o    <= 1'b0;
            data_done_o  <= 1'b0;
        end else begin
            if_done_o   <= xfer_done && (state == ST_IF_BUSY);
            data_done_o <= xfer_done && (state == ST_DATA_BUSY);

            if (grant_data) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= data_we_i;
                mem_addr_o  <= data_addr_i;
                mem_sel_o   <= data_sel_i;
                mem_wdata_o <= data_wdata_i;
            end else if (grant_if) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= 1'b0;
                mem_addr_o  <= if_addr_i & ~ADDR_W'(3);
                mem_sel_o   <= SEL_ALL;
                mem_wdata_o <= '0;
            end else if (xfer_done) begin
                mem_req_o <= 1'b0;
            end

            // The registered write enable is used so a changed data_we_i cannot corrupt the capture.
            if (xfer_done && (state == ST_IF_BUSY)) begin
                if_rdata_o <= mem_rdata_i;
            end
            if (xfer_done && (state == ST_DATA_BUSY) && !mem_we_o) begin
                data_rdata_o <= mem_rdata_i;
            end
        end
    end

    assign stall_o = (if_req_i & ~if_done_o) | (data_req_i & ~data_done_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus hand sequences
// for arbitration order, mid-transaction request drop and reset abandonment.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_done_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic [3:0]  data_sel_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_done_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_rdata_o   (if_rdata_o),
        .if_done_o    (if_done_o),
        .data_req_i   (data_req_i),
        .data_we_i    (data_we_i),
        .data_addr_i  (data_addr_i),
        .data_sel_i   (data_sel_i),
        .data_wdata_i (data_wdata_i),
        .data_rdata_o (data_rdata_o),
        .data_done_o  (data_done_o),
        .stall_o      (stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_sel_o    (mem_sel_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ready_i  (mem_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] exp_addr;
        logic [3:0]  exp_sel;
        logic [31:0] exp_if_rd;
        logic [31:0] exp_data_rd;
    } vec_t;

    vec_t vecs[6];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_i     = 1'b0;
        if_addr_i    = '0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_addr_i  = '0;
        data_sel_i   = '0;
        data_wdata_i = '0;
        mem_rdata_i  = '0;
        mem_ready_i  = 1'b0;
    endtask

    // Called just after a rising edge with the arbiter idle.
    task automatic run_vec(input vec_t v, input int idx);
        logic exp_we;
        exp_we = v.is_data ? v.we : 1'b0;
        if (v.is_data) begin
            data_req_i   = 1'b1;
            data_we_i    = v.we;
            data_addr_i  = v.addr;
            data_sel_i   = v.sel;
            data_wdata_i = v.wdata;
        end else begin
            if_req_i  = 1'b1;
            if_addr_i = v.addr;
        end
        #1;
        chk($sformatf("v%0d stall_req", idx), stall_o, 1'b1);
        step();
        for (int w = 0; w <= v.waits; w++) begin
            chk($sformatf("v%0d mem_req w%0d", idx, w), mem_req_o, 1'b1);
            chk($sformatf("v%0d mem_addr w%0d", idx, w), mem_addr_o, v.exp_addr);
            chk($sformatf("v%0d mem_sel w%0d", idx, w), mem_sel_o, v.exp_sel);
            chk($sformatf("v%0d mem_we w%0d", idx, w), mem_we_o, exp_we);
            chk($sformatf("v%0d stall_busy w%0d", idx, w), stall_o, 1'b1);
            if (v.is_data) chk($sformatf("v%0d mem_wdata w%0d", idx, w), mem_wdata_o, v.wdata);
            mem_ready_i = (w == v.waits);
            mem_rdata_i = v.rdata;
            step();
        end
        chk($sformatf("v%0d if_done", idx), if_done_o, !v.is_data);
        chk($sformatf("v%0d data_done", idx), data_done_o, v.is_data);
        chk($sformatf("v%0d mem_req_clr", idx), mem_req_o, 1'b0);
        chk($sformatf("v%0d stall_done", idx), stall_o, 1'b0);
        chk($sformatf("v%0d if_rdata", idx), if_rdata_o, v.exp_if_rd);
        chk($sformatf("v%0d data_rdata", idx), data_rdata_o, v.exp_data_rd);
        idle_inputs();
        step();
        chk($sformatf("v%0d if_done_end", idx), if_done_o, 1'b0);
        chk($sformatf("v%0d data_done_end", idx), data_done_o, 1'b0);
    endtask

    initial begin
        //          data we  addr          sel      wdata         rdata         w  exp_addr      sel      if_rd         data_rd
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0006, 4'b0000, 32'h0,        32'h0000_0013, 0, 32'h0000_0004, 4'b1111, 32'h0000_0013, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 4'b0011, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 3, 32'h0000_0100, 4'b0011, 32'h0000_0013, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0200, 4'b1111, 32'h0,        32'h1234_5678, 1, 32'h0000_0200, 4'b1111, 32'h0000_0013, 32'h1234_5678};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0103, 4'b0000, 32'h0,        32'hAABB_CCDD, 2, 32'h0000_0100, 4'b1111, 32'hAABB_CCDD, 32'h1234_5678};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0300, 4'b1000, 32'h0000_0055, 32'h0,        0, 32'h0000_0300, 4'b1000, 32'hAABB_CCDD, 32'h1234_5678};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_07FC, 4'b0100, 32'h0,        32'h00AB_0000, 0, 32'h0000_07FC, 4'b0100, 32'hAABB_CCDD, 32'h00AB_0000};

        rst = 1'b0;
        idle_inputs();
        #3;
        chk("rst mem_req", mem_req_o, 1'b0);
        chk("rst mem_we", mem_we_o, 1'b0);
        chk("rst mem_sel", mem_sel_o, 4'b0000);
        chk("rst mem_addr", mem_addr_o, 32'h0);
        chk("rst mem_wdata", mem_wdata_o, 32'h0);
        chk("rst if_rdata", if_rdata_o, 32'h0);
        chk("rst data_rdata", data_rdata_o, 32'h0);
        chk("rst if_done", if_done_o, 1'b0);
        chk("rst data_done", data_done_o, 1'b0);
        chk("rst stall_idle", stall_o, 1'b0);
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0010;
        #1;
        chk("rst stall_follows", stall_o, 1'b1);
        step();
        chk("rst no_grant_in_reset", mem_req_o, 1'b0);

        // Release between edges with a fetch already pending: grant lands on the next edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel no_grant_before_edge", mem_req_o, 1'b0);
        step();
        chk("rel first_grant", mem_req_o, 1'b1);
        chk("rel first_addr", mem_addr_o, 32'h0000_0010);
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h0000_0000;
        step();
        chk("rel first_done", if_done_o, 1'b1);
        idle_inputs();
        step();

        // Stray mem_ready_i while idle must not produce anything.
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h5555_5555;
        step();
        step();
        chk("idle_ready if_done", if_done_o, 1'b0);
        chk("idle_ready data_done", data_done_o, 1'b0);
        chk("idle_ready mem_req", mem_req_o, 1'b0);
        chk("idle_ready if_rdata", if_rdata_o, 32'h0);
        idle_inputs();
        step();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // Fresh reset so the fairness flag starts clear for the contention run.
        #2;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();

        begin
            logic [31:0] arb_addr[4];
            arb_addr[0] = 32'h0000_0080;
            arb_addr[1] = 32'h0000_0040;
            arb_addr[2] = 32'h0000_0080;
            arb_addr[3] = 32'h0000_0040;
            if_req_i    = 1'b1;
            if_addr_i   = 32'h0000_0040;
            data_req_i  = 1'b1;
            data_we_i   = 1'b0;
            data_addr_i = 32'h0000_0080;
            data_sel_i  = 4'b1111;
            for (int k = 0; k < 4; k++) begin
                step();
                chk($sformatf("arb%0d mem_req", k), mem_req_o, 1'b1);
                chk($sformatf("arb%0d grant_addr", k), mem_addr_o, arb_addr[k]);
                mem_ready_i = 1'b1;
                step();
                chk($sformatf("arb%0d data_done", k), data_done_o, (k % 2) == 0);
                chk($sformatf("arb%0d if_done", k), if_done_o, (k % 2) == 1);
                mem_ready_i = 1'b0;
            end
            idle_inputs();
            step();
            chk("arb idle_after", mem_req_o, 1'b0);
        end

        // Load whose request is withdrawn while the memory is still busy.
        data_req_i  = 1'b1;
        data_we_i   = 1'b0;
        data_addr_i = 32'h0000_0200;
        data_sel_i  = 4'b1111;
        step();
        chk("drop mem_req", mem_req_o, 1'b1);
        chk("drop mem_addr", mem_addr_o, 32'h0000_0200);
        data_req_i = 1'b0;
        step();
        step();
        chk("drop still_busy", mem_req_o, 1'b1);
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h1234_5678;
        step();
        chk("drop data_done", data_done_o, 1'b1);
        chk("drop data_rdata", data_rdata_o, 32'h1234_5678);
        idle_inputs();
        step();
        chk("drop done_once", data_done_o, 1'b0);

        // Reset in the middle of a store abandons it without any edge.
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_addr_i  = 32'h0000_0400;
        data_sel_i   = 4'b1111;
        data_wdata_i = 32'h0000_0001;
        step();
        chk("abort mem_req_busy", mem_req_o, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("abort mem_req_async", mem_req_o, 1'b0);
        chk("abort mem_addr", mem_addr_o, 32'h0);
        chk("abort data_rdata", data_rdata_o, 32'h0);
        data_req_i  = 1'b0;
        mem_ready_i = 1'b1;
        step();
        chk("abort no_data_done", data_done_o, 1'b0);
        mem_ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("abort post_data_done", data_done_o, 1'b0);
        run_vec(vecs[0], 6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width in bits.
REQ-002 Parameter DATA_W, 32, data width in bits; fixed at 32 because the byte-select width is 4.
REQ-003 Clocking SHALL be one clock, clk; reset SHALL be rst, asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 if_req_i  in  1  core instruction-fetch request (ce).
REQ-007 if_addr_i  in  ADDR_W  fetch byte address.
REQ-008 if_rdata_o  out  DATA_W  fetched instruction word.
REQ-009 if_done_o  out  1  one-cycle fetch-complete pulse.
REQ-010 data_req_i  in  1  core load/store request (ce).
REQ-011 data_we_i  in  1  1 = store, 0 = load.
REQ-012 data_addr_i  in  ADDR_W  load/store byte address.
REQ-013 data_sel_i  in  4  byte lanes.
REQ-014 data_wdata_i  in  DATA_W  store data.
REQ-015 data_rdata_o  out  DATA_W  load result.
REQ-016 data_done_o  out  1  one-cycle load/store-complete pulse.
REQ-017 stall_o  out  1  pipeline stall to the core.
REQ-018 mem_req_o, mem_we_o  out  1 each  single-port memory request and write enable.
REQ-019 mem_addr_o  out  ADDR_W  memory address; mem_sel_o  out  4  memory byte lanes; mem_wdata_o  out  DATA_W  memory write data.
REQ-020 mem_rdata_i  in  DATA_W  memory read data; mem_ready_i  in  1  memory access complete, variable latency of at least 1 cycle.

Function
REQ-021 The arbiter SHALL use a three-state FSM: IDLE, IF_BUSY, DATA_BUSY.
REQ-022 In IDLE with data_req_i=1, the FSM SHALL go to DATA_BUSY unless the fairness flag is set and if_req_i=1.
REQ-023 In IDLE, if the fetch request wins, the FSM SHALL go to IF_BUSY; with no request it SHALL stay in IDLE.
REQ-024 The fairness flag SHALL set on completion of a data transfer and clear on completion of a fetch, so two back-to-back contenders alternate starting with data.
REQ-025 The mem_* outputs SHALL be registered at the grant edge and held stable until the edge after mem_ready_i=1.
REQ-026 A fetch SHALL drive mem_we_o=0, mem_sel_o=4'b1111, mem_addr_o={if_addr_i[31:2],2'b00}.
REQ-027 A data access SHALL pass data_we_i, data_sel_i, data_addr_i and data_wdata_i through unchanged.
REQ-028 On a cycle with mem_ready_i=1 in a BUSY state, at that edge the FSM SHALL: return to IDLE, clear mem_req_o, pulse the matching done output for exactly the next cycle, and capture mem_rdata_i into if_rdata_o or data_rdata_o.
REQ-029 Loads SHALL capture mem_rdata_i; stores SHALL leave data_rdata_o unchanged.
REQ-030 The rdata outputs SHALL hold their value until the next capture of the same type.
REQ-031 Minimum latency SHALL be request seen in IDLE at cycle N, mem_req_o high at N+1, done at N+2 (mem_ready_i=1 at N+1).
REQ-032 No back-to-back issue: in the done cycle the FSM is in IDLE and MAY grant, with mem_req_o high again the following cycle.
REQ-033 mem_ready_i SHALL be ignored in IDLE.
REQ-034 A request deasserted mid-transaction SHALL NOT abort: the access completes and done still pulses.
REQ-035 stall_o SHALL be combinational: (if_req_i & ~if_done_o) | (data_req_i & ~data_done_o).

Reset
REQ-036 While rst=0, asynchronously: state=IDLE, fairness flag=0, and all outputs 0 (mem_req_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o, both rdata outputs, both done pulses); stall_o follows REQ-035.
REQ-037 On reset assertion mid-transaction, mem_req_o SHALL drop immediately and the transaction SHALL be abandoned with no done pulse.
REQ-038 The first grant after reset SHALL occur no earlier than the first rising edge with rst=1.

Structure
REQ-039 Bus-width macros (RegBus, InstAddrBus, InstBus), the SEL_ALL=4'b1111 constant and FSM state encodings SHALL live in the shared defines file.
REQ-040 mem_arbiter SHALL be a single module with no sub-module; it sits between riscv and a unified single-port memory.

Verification
REQ-041 Fetch at 0x0000_0006, mem_ready_i one cycle after mem_req_o, mem_rdata_i=0x0000_0013 -> mem_addr_o=0x0000_0004, sel=1111, if_done_o one cycle, if_rdata_o=0x13, total 2 cycles.
REQ-042 Store addr 0x100, sel 0011, wdata 0xDEAD_BEEF, mem_ready_i after 3 wait cycles -> mem_* stable for 4 cycles, data_done_o pulse, data_rdata_o unchanged, stall_o high until the done cycle.
REQ-043 if_req_i and data_req_i held together for 4 transactions -> grant order DATA, IF, DATA, IF.
REQ-044 Load 0x200 returning 0x1234_5678, then data_req_i dropped mid-wait -> access still completes with data_done_o and data_rdata_o=0x1234_5678.
REQ-045 rst=0 asserted while in DATA_BUSY -> mem_req_o=0 with no clock edge, no done pulse; after rst=1 a fresh fetch completes normally.
